// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone prefix adder.
package prefix_adder_pkg;

  // Generate/propagate pair; after prefix levels these hold group G/P.
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // One operand-registration stage plus ceil(levels / reg_every) prefix stages.
  function automatic int num_stages(input int width, input int reg_every);
    return 1 + (clog2(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle between the ALU datapath and the prefix adder.
interface pipelined_prefix_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone level: merges each bit's (G,P) with the group SPAN bits below.
module prefix_level
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPAN  = 1
) (
  input  pg_t [WIDTH-1:0] pg_in,
  output pg_t [WIDTH-1:0] pg_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < SPAN) begin : g_pass
      assign pg_out[i] = pg_in[i];
    end else begin : g_merge
      assign pg_out[i].g = pg_in[i].g | (pg_in[i].p & pg_in[i-SPAN].g);
      assign pg_out[i].p = pg_in[i].p & pg_in[i-SPAN].p;
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder with a global-stall valid/ready handshake.
// Define PREFIX_ADDER_SUB_EN to honour the sub input (a - b); otherwise sub is ignored.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  pipelined_prefix_adder_if.slave  bus
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int NSTG   = num_stages(WIDTH, REG_EVERY);

  logic             advance;
  logic [WIDTH-1:0] bm;
  logic             cin_eff;
  pg_t [WIDTH-1:0]  pg_in;

  logic [NSTG-1:0]  vld_p;
  pg_t [WIDTH-1:0]  pg_p   [NSTG-1];
  logic [WIDTH-1:0] praw_p [NSTG-1];
  logic             cin_p  [NSTG-1];
  logic             amsb_p [NSTG-1];
  logic             bmsb_p [NSTG-1];

  pg_t [WIDTH-1:0]  lvl_out [LEVELS];

  logic [WIDTH-1:0] gfin;
  logic [WIDTH-1:0] pfin;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

`ifdef PREFIX_ADDER_SUB_EN
  assign bm      = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;
`else
  logic unused_sub;
  assign bm         = bus.b;
  assign cin_eff    = bus.cin;
  assign unused_sub = bus.sub;
`endif

  assign advance       = !vld_p[NSTG-1] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p[NSTG-1];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // Carry-in folded into bit 0 so the prefix tree yields carries that already include it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pg_in[i].g = bus.a[i] & bm[i];
      pg_in[i].p = bus.a[i] ^ bm[i];
    end
    pg_in[0].g = (bus.a[0] & bm[0]) | ((bus.a[0] ^ bm[0]) & cin_eff);
  end

  // ---- stage 0: bitwise generate/propagate, carry-in, operand MSBs ----
  always_ff @(posedge clk) begin
    if (advance) begin
      pg_p[0]   <= pg_in;
      praw_p[0] <= bus.a ^ bm;
      cin_p[0]  <= cin_eff;
      amsb_p[0] <= bus.a[WIDTH-1];
      bmsb_p[0] <= bm[WIDTH-1];
    end
  end

  // Level k lives in stage 1 + k/REG_EVERY; the first level of a stage reads that stage's input register.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int STG = 1 + k / REG_EVERY;
    pg_t [WIDTH-1:0] lin;
    if (k % REG_EVERY == 0) begin : g_head
      assign lin = pg_p[STG-1];
    end else begin : g_chain
      assign lin = lvl_out[k-1];
    end
    prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << k)
    ) u_level (
      .pg_in  (lin),
      .pg_out (lvl_out[k])
    );
  end

  // ---- stages 1..NSTG-2: REG_EVERY prefix levels each ----
  for (genvar s = 1; s < NSTG - 1; s++) begin : g_stage
    always_ff @(posedge clk) begin
      if (advance) begin
        pg_p[s]   <= lvl_out[s*REG_EVERY-1];
        praw_p[s] <= praw_p[s-1];
        cin_p[s]  <= cin_p[s-1];
        amsb_p[s] <= amsb_p[s-1];
        bmsb_p[s] <= bmsb_p[s-1];
      end
    end
  end

  // Group P of the final level is not needed; only the carries feed the sum.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      gfin[i] = lvl_out[LEVELS-1][i].g;
      pfin[i] = lvl_out[LEVELS-1][i].p;
    end
    sum_c  = praw_p[NSTG-2] ^ {gfin[WIDTH-2:0], cin_p[NSTG-2]};
    cout_c = gfin[WIDTH-1];
    ovf_c  = (amsb_p[NSTG-2] == bmsb_p[NSTG-2]) && (sum_c[WIDTH-1] != amsb_p[NSTG-2]);
  end

  logic unused_pfin;
  assign unused_pfin = ^pfin;

  // ---- final stage: result registers and the valid chain ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      vld_p  <= {vld_p[NSTG-2:0], bus.in_valid};
      sum_q  <= sum_c;
      cout_q <= cout_c;
      ovf_q  <= ovf_c;
    end
  end

endmodule
